// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with per-channel ratio/enable applied at period boundaries.
// Optional macro CLKDIV_DUTY50_EN: falling-edge stage giving exact 50% duty for odd ratios.
module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                            i_ref_clk,
  input  logic                            i_rst,
  input  logic [CHANNELS-1:0]             i_clk_en,
  input  logic [CHANNELS*RATIO_WIDTH-1:0] i_div_ratio,
  output logic [CHANNELS-1:0]             o_div_clk,
  output logic [CHANNELS-1:0]             o_div_tick,
  output logic [CHANNELS-1:0]             o_active
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [RATIO_WIDTH-1:0] ratio;
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] req_ratio;
    logic [RATIO_WIDTH-1:0] low_last;
    logic [RATIO_WIDTH-1:0] high_last;
    logic                   div;
    logic                   active;
    logic                   tick;
    logic                   div_out;
    logic                   req_valid;
    logic                   set_hi;
    logic                   end_period;
    logic                   load;

    assign req_ratio = i_div_ratio[n*RATIO_WIDTH +: RATIO_WIDTH];
    assign req_valid = i_clk_en[n] && (req_ratio >= RATIO_WIDTH'(2));

    // Last count of each phase: L-1 = (R-1)/2, H-1 = R/2 - 1 (R >= 2 whenever active).
    assign low_last  = (ratio - 1'b1) >> 1;
    assign high_last = (ratio >> 1) - 1'b1;

    assign set_hi     = active && !div && (cnt == low_last);
    assign end_period = active && div && (cnt == high_last);
    assign load       = !active || end_period;

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        ratio  <= '0;
        cnt    <= '0;
        div    <= 1'b0;
        active <= 1'b0;
        tick   <= 1'b0;
      end else if (load) begin
        ratio  <= req_ratio;
        active <= req_valid;
        cnt    <= '0;
        div    <= 1'b0;
        tick   <= 1'b0;
      end else if (set_hi) begin
        cnt    <= '0;
        div    <= 1'b1;
        tick   <= 1'b1;
      end else begin
        cnt    <= cnt + 1'b1;
        tick   <= 1'b0;
      end
    end

`ifdef CLKDIV_DUTY50_EN
    // Half-cycle early rise for odd ratios: set on the falling edge just before the rising edge that sets div.
    logic early;

    always_ff @(negedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        early <= 1'b0;
      end else begin
        early <= active && !div && ratio[0] && (cnt == low_last);
      end
    end

    assign div_out = div || early;
`else
    assign div_out = div;
`endif

    assign o_div_clk[n]  = active ? div_out : i_ref_clk;
    assign o_div_tick[n] = tick;
    assign o_active[n]   = active;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: period-position reference model feeding a scoreboard queue.
module tb_clk_div_multi;
  localparam int CH = 4;
  localparam int RW = 8;
`ifdef CLKDIV_DUTY50_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CH-1:0]    clk_en = '0;
  logic [CH*RW-1:0] div_ratio = '0;
  logic [CH-1:0]    div_clk;
  logic [CH-1:0]    div_tick;
  logic [CH-1:0]    active;

  clk_div_multi #(.CHANNELS(CH), .RATIO_WIDTH(RW)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_clk_en   (clk_en),
    .i_div_ratio(div_ratio),
    .o_div_clk  (div_clk),
    .o_div_tick (div_tick),
    .o_active   (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] act;
    logic [CH-1:0] tick;
    logic [CH-1:0] clk_hi;
    logic [CH-1:0] clk_lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_act[CH];
  int   m_r[CH];
  int   m_pos[CH];

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      m_act[n] = 0;
      m_r[n]   = 0;
      m_pos[n] = 0;
    end
  endtask

  // Position-in-period model: pos counts ref edges since the last period start.
  task automatic model_edge();
    exp_t e;
    int   r;
    int   lo;
    for (int n = 0; n < CH; n++) begin
      r = int'(div_ratio[n*RW +: RW]);
      if (m_act[n] == 0 || m_pos[n] == m_r[n] - 1) begin
        m_act[n] = (clk_en[n] && r >= 2) ? 1 : 0;
        m_r[n]   = r;
        m_pos[n] = 0;
      end else begin
        m_pos[n]++;
      end
      lo = (m_r[n] + 1) / 2;
      e.act[n]    = (m_act[n] != 0);
      e.tick[n]   = (m_act[n] != 0) && (m_pos[n] == lo);
      e.clk_hi[n] = (m_act[n] != 0) ? (m_pos[n] >= lo) : 1'b1;
      e.clk_lo[n] = (m_act[n] != 0) ?
                    ((m_pos[n] >= lo) || (DUTY && (m_r[n] % 2 == 1) && (m_pos[n] == lo - 1))) : 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk); #1;
    e = sb.pop_front();
    check("active", active, e.act);
    check("tick", div_tick, e.tick);
    check("div_clk_high_half", div_clk, e.clk_hi);
    @(negedge clk); #1;
    check("div_clk_low_half", div_clk, e.clk_lo);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_ch(input int n, input logic en, input int r);
    clk_en[n] = en;
    div_ratio[n*RW +: RW] = RW'(r);
  endtask

  // Called with the clock low (just after a falling edge): async assert, hold over one rising edge, release.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_active", active, '0);
    check("rst_tick", div_tick, '0);
    check("rst_bypass_low", div_clk, '0);
    @(posedge clk); #1;
    check("rst_bypass_high", div_clk, '1);
    check("rst_active_hold", active, '0);
    rst = 1'b0;
    model_reset();
    @(negedge clk); #1;
  endtask

  initial begin
    model_reset();
    #2;
    reset_pulse();

    // ch0 R=4
    set_ch(0, 1'b1, 4);
    run(12);

    // ch1 R=5 alongside ch0
    set_ch(1, 1'b1, 5);
    run(15);

    // ch0 ratio 4->6 during a high phase
    for (int k = 0; k < 8 && !(m_act[0] != 0 && m_pos[0] >= (m_r[0] + 1) / 2); k++) step();
    set_ch(0, 1'b1, 6);
    run(14);

    // ch2 R=8 disabled mid low phase by enable=0, ratio=1, ratio=0
    for (int kind = 0; kind < 3; kind++) begin
      set_ch(2, 1'b1, 8);
      run(1);
      for (int k = 0; k < 20 && !(m_act[2] != 0 && m_pos[2] == 1); k++) step();
      case (kind)
        0:       set_ch(2, 1'b0, 8);
        1:       set_ch(2, 1'b1, 1);
        default: set_ch(2, 1'b1, 0);
      endcase
      run(12);
    end

    // Reset during a high phase on all channels
    for (int n = 0; n < CH; n++) set_ch(n, 1'b0, 0);
    reset_pulse();
    for (int n = 0; n < CH; n++) set_ch(n, 1'b1, 4);
    run(3);
    reset_pulse();
    run(10);

    // Concurrent R=2, R=3, R=255, ch3 disabled
    set_ch(0, 1'b1, 2);
    set_ch(1, 1'b1, 3);
    set_ch(2, 1'b1, 255);
    set_ch(3, 1'b0, 4);
    run(530);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel integer clock divider that generates CHANNELS independent divided clocks from one reference clock, each with its own ratio and enable. Ratio and enable changes are applied only at divided-period boundaries, so no channel ever emits a truncated pulse. Each channel also provides a single-cycle tick aligned to its divided-clock rising edge. The block sits in the clock-generation area and feeds the UART TX/RX baud clocks and other slow-domain consumers.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- RATIO_WIDTH, 8, width of each channel's division ratio
- i_ref_clk  input  1  reference clock; all logic on its rising edge (plus one falling-edge stage under CLKDIV_DUTY50_EN)
- i_rst  input  1  asynchronous, active-high reset
- i_clk_en  input  CHANNELS  per-channel enable request
- i_div_ratio  input  CHANNELS*RATIO_WIDTH  packed ratios; channel n uses bits [n*RATIO_WIDTH +: RATIO_WIDTH]
- o_div_clk  output  CHANNELS  divided clock; follows i_ref_clk when the channel is inactive
- o_div_tick  output  CHANNELS  registered one-cycle pulse during the first ref cycle of each high phase
- o_active  output  CHANNELS  registered; 1 while the channel is dividing

## Operation
- Each channel holds a shadow ratio R, a counter (RATIO_WIDTH bits), a div_clk register and an active flag.
- Valid request: i_clk_en[n]=1 and ratio >= 2. Ratios 0 and 1 count as disable.
- Each period has a low phase L = ceil(R/2) cycles, then a high phase H = floor(R/2) cycles. L + H = R.
- Load points: (a) any cycle while inactive; (b) the edge that ends a high phase (div_clk 1->0). At a load point the channel samples i_clk_en/i_div_ratio, sets active = valid request, latches R and clears the counter.
- Inactive: counter=0, div_clk=0, o_div_tick=0, o_div_clk = i_ref_clk (combinational bypass).
- Active: the counter increments. At counter == L-1 in the low phase, div_clk goes to 1 and the counter clears. At counter == H-1 in the high phase, the period ends: div_clk goes to 0 and a load point occurs.
- Mid-period changes to ratio or enable are ignored until the next load point. Disable therefore completes the current high phase before bypass resumes.
- Channels are fully independent and share no state.

## Timing
- Reset (asynchronous, immediate, including mid-period): all counters 0, div_clk 0, o_active 0, o_div_tick 0, so o_div_clk = i_ref_clk. Shadow ratios reset to 0.
- Enable from inactive: the valid request is sampled at edge E0, and o_active=1 after E0. o_div_clk rises after edge E0+L and falls after edge E0+R. The next rise follows after E0+R+L.
- o_div_tick is high exactly during the ref cycle following the edge that sets div_clk to 1. Its period is R ref cycles.
- Disable or invalid ratio seen at a period end: o_active drops and bypass starts after that same edge.
- Ratio R=2: 1 cycle low, 1 cycle high. R=2^RATIO_WIDTH-1: L=2^(RATIO_WIDTH-1), H=L-1. The counter never wraps because it clears at every phase end.

## Configuration
- CLKDIV_DUTY50_EN defined: for odd R, a falling-edge i_ref_clk stage advances the rise of o_div_clk by half a ref cycle. This gives exact 50% duty (R/2 low, R/2 high). Even ratios, fall timing, o_div_tick and o_active are unchanged.
- Not defined: odd ratios give (R+1)/2 low and (R-1)/2 high, there are no falling-edge flops, and the block is fully rising-edge.

## Test plan
- Reset, then ch0 enabled with R=4 -> o_active[0]=1 after 1 edge; o_div_clk[0] shows 2 low and 2 high, period 4; o_div_tick[0] pulses every 4 cycles, aligned with the first high cycle.
- ch1 R=5 -> without the macro, 3 low and 2 high; with CLKDIV_DUTY50_EN, 2.5 low and 2.5 high (rise on the ref falling edge); tick period 5 in both builds.
- ch0 R changed 4->6 during a high phase -> the current period completes with 4 cycles; following periods are 3 low and 3 high; no high pulse shorter than 2 cycles.
- ch2 running R=8, then i_clk_en=0 (or R=1, or R=0) mid low phase -> the remaining low phase and the full 4-cycle high phase complete; then o_active=0, o_div_clk follows i_ref_clk, ticks stop.
- i_rst pulsed during a high phase on all channels -> immediate bypass and o_active=0; after release with the same enables, each channel restarts with a full L-cycle low phase.
- Concurrent ch0 R=2, ch1 R=3, ch2 R=255, ch3 disabled -> tick periods 2, 3 and 255; ch3 bypassed; no cross-channel interaction.
